// File: rtl/pwm_ramp_ctrl.sv
// Avalon-MM PWM generator with a duty-ramping FSM and safe direction reversal.
// Duty changes only at period boundaries. Direction changes only while the duty is zero.
module pwm_ramp_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic        sens_out,
    output logic [15:0] duty_now
);
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, REVERSE} state_e;

    state_e      state_q, state_d;
    logic        enable_q, enable_d, sens_req_q, sens_req_d;
    logic [15:0] period_q, duty_q, cnt_q, cnt_d, duty_now_q, duty_now_d;
    logic [7:0]  step_q;
    logic        pwm_q, pwm_d, sens_out_q, sens_out_d;
    logic        wr, active, bnd;
    logic [15:0] target, ramp_nxt;

    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt,
                                                input logic [7:0]  st);
        logic [15:0] s;
        s = {8'd0, st};
        if (st == 8'd0)
            return tgt;
        if (cur < tgt)
            return (tgt - cur <= s) ? tgt : cur + s;
        return (cur - tgt <= s) ? tgt : cur - s;
    endfunction

    assign wr         = chipselect & ~write_n;
    assign enable_d   = (wr && address == 2'd0) ? writedata[0] : enable_q;
    assign sens_req_d = (wr && address == 2'd0) ? writedata[1] : sens_req_q;

    // cnt >= PERIOD-1 also catches a PERIOD shrunk below the current count
    assign active = enable_q && (period_q >= 16'd2);
    assign bnd    = active && (cnt_q >= period_q - 16'd1);
    assign cnt_d  = (!active || bnd || !enable_d) ? 16'd0 : cnt_q + 16'd1;
    assign pwm_d  = active && enable_d && (cnt_q < duty_now_q);

    assign target   = (duty_q > period_q) ? period_q : duty_q;
    assign ramp_nxt = step_toward(duty_now_q, target, step_q);

    always_comb begin
        state_d    = state_q;
        duty_now_d = duty_now_q;
        sens_out_d = sens_out_q;
        if (!enable_d) begin
            state_d    = IDLE;
            duty_now_d = 16'd0;
        end else if (state_q == IDLE) begin
            if (enable_q) begin
                state_d    = RAMP;
                sens_out_d = sens_req_q;
            end
        end else if (bnd) begin
            if (sens_req_q != sens_out_q && duty_now_q != 16'd0) begin
                state_d    = REVERSE;
                duty_now_d = step_toward(duty_now_q, 16'd0, step_q);
            end else begin
                // duty_now is 0 here whenever the direction flips, so pwm is low
                sens_out_d = sens_req_q;
                duty_now_d = ramp_nxt;
                state_d    = (ramp_nxt == target) ? HOLD : RAMP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            sens_req_q <= 1'b0;
            period_q   <= 16'd0;
            duty_q     <= 16'd0;
            step_q     <= 8'd0;
            cnt_q      <= 16'd0;
            state_q    <= IDLE;
            duty_now_q <= 16'd0;
            pwm_q      <= 1'b0;
            sens_out_q <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            sens_req_q <= sens_req_d;
            if (wr && address == 2'd1) period_q <= writedata[15:0];
            if (wr && address == 2'd2) duty_q   <= writedata[15:0];
            if (wr && address == 2'd3) step_q   <= writedata[7:0];
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            duty_now_q <= duty_now_d;
            pwm_q      <= pwm_d;
            sens_out_q <= sens_out_d;
        end
    end

    always_comb begin
        case (address)
            2'd0:    readdata = {30'd0, sens_req_q, enable_q};
            2'd1:    readdata = {16'd0, period_q};
            2'd2:    readdata = {16'd0, duty_q};
            default: readdata = {duty_now_q, 6'd0, state_q == HOLD,
                                 (state_q == RAMP) || (state_q == REVERSE), step_q};
        endcase
    end

    assign pwm_out  = pwm_q;
    assign sens_out = sens_out_q;
    assign duty_now = duty_now_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: expected values are queued before stimulus
// and popped as the DUT produces them.
module tb_pwm_ramp_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pwm_out, sens_out;
    logic [15:0] duty_now;

    pwm_ramp_ctrl dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pwm_out(pwm_out), .sens_out(sens_out), .duty_now(duty_now)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];
    int   npass = 0;
    int   ntot  = 0;

    int   sens_viol = 0;
    logic sens_prev = 1'b0;
    logic pwm_prev  = 1'b0;
    always @(negedge clk) begin
        if (reset_n && (sens_out !== sens_prev) && (pwm_out || pwm_prev))
            sens_viol <= sens_viol + 1;
        sens_prev <= sens_out;
        pwm_prev  <= pwm_out;
    end

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        ntot++;
        if (sb.size() == 0) begin
            e.tag = "empty_queue";
            e.v   = 32'hDEAD_BEEF;
        end else begin
            e = sb.pop_front();
        end
        assert (obs === e.v) npass++;
        else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Waits for duty_now to move; a timeout yields an impossible value.
    task automatic wait_duty(output logic [31:0] obs);
        logic [15:0] old;
        old = duty_now;
        obs = 32'hFFFF_FFFF;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (duty_now !== old) begin
                obs = {16'd0, duty_now};
                break;
            end
        end
    endtask

    task automatic wait_pwm_high(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        ok;
        int          hi;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // reset state
        for (int a = 0; a < 4; a++) push($sformatf("reset_reg%0d", a), 32'd0);
        push("reset_pwm", 32'd0);
        push("reset_sens", 32'd0);
        push("reset_duty", 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            pop_chk(d);
        end
        pop_chk({31'd0, pwm_out});
        pop_chk({31'd0, sens_out});
        pop_chk({16'd0, duty_now});

        // STEP=0 jump to 25/100
        push("jump_duty", 32'd25);
        push("jump_highs", 32'd25);
        push("jump_status", (32'd25 << 16) | (32'd1 << 9));
        wr(2'd1, 32'd100);
        wr(2'd2, 32'd25);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd1);
        wait_duty(d);
        pop_chk(d);
        count_high(100, hi);
        pop_chk(hi);
        rd(2'd3, d);
        pop_chk(d);

        // disable then ramp 10,20,30,35
        push("dis_duty", 32'd0);
        push("dis_pwm", 32'd0);
        wr(2'd0, 32'd0);
        pop_chk({16'd0, duty_now});
        pop_chk({31'd0, pwm_out});

        push("ramp_10", 32'd10);
        push("ramp_status_10", (32'd10 << 16) | (32'd1 << 8) | 32'd10);
        push("ramp_20", 32'd20);
        push("ramp_30", 32'd30);
        push("ramp_35", 32'd35);
        push("ramp_status_35", (32'd35 << 16) | (32'd1 << 9) | 32'd10);
        push("ramp_highs_35", 32'd35);
        wr(2'd3, 32'd10);
        wr(2'd2, 32'd35);
        wr(2'd0, 32'd1);
        wait_duty(d);
        pop_chk(d);
        rd(2'd3, d);
        pop_chk(d);
        for (int i = 0; i < 3; i++) begin
            wait_duty(d);
            pop_chk(d);
        end
        rd(2'd3, d);
        pop_chk(d);
        count_high(100, hi);
        pop_chk(hi);

        // reverse: hold 40, STEP=20, flip direction
        push("pre_rev_40", 32'd40);
        wr(2'd3, 32'd20);
        wr(2'd2, 32'd40);
        wait_duty(d);
        pop_chk(d);
        push("rev_20", 32'd20);
        push("rev_20_sens", 32'd0);
        push("rev_status", (32'd20 << 16) | (32'd1 << 8) | 32'd20);
        push("rev_0", 32'd0);
        push("rev_0_sens", 32'd0);
        push("fwd_20", 32'd20);
        push("fwd_20_sens", 32'd1);
        push("fwd_40", 32'd40);
        push("fwd_40_sens", 32'd1);
        push("sens_while_pwm", 32'd0);
        wr(2'd0, 32'd3);
        wait_duty(d);
        pop_chk(d);
        pop_chk({31'd0, sens_out});
        rd(2'd3, d);
        pop_chk(d);
        for (int i = 0; i < 3; i++) begin
            wait_duty(d);
            pop_chk(d);
            pop_chk({31'd0, sens_out});
        end
        pop_chk(sens_viol);

        // saturation then PERIOD=1
        push("sat_duty", 32'd100);
        push("sat_highs", 32'd200);
        push("p1_highs", 32'd0);
        push("p1_readback", 32'd1);
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd150);
        wait_duty(d);
        pop_chk(d);
        repeat (2) @(negedge clk);
        count_high(200, hi);
        pop_chk(hi);
        wr(2'd1, 32'd1);
        repeat (2) @(negedge clk);
        count_high(50, hi);
        pop_chk(hi);
        rd(2'd1, d);
        pop_chk(d);

        // disable mid-ramp at 30
        push("kill_prep_duty", 32'd0);
        wr(2'd0, 32'd0);
        pop_chk({16'd0, duty_now});
        push("mr_10", 32'd10);
        push("mr_sens", 32'd0);
        push("mr_20", 32'd20);
        push("mr_30", 32'd30);
        push("mr_pwm_seen", 32'd1);
        push("kill_pwm", 32'd0);
        push("kill_duty", 32'd0);
        push("kill_status", 32'd10);
        wr(2'd1, 32'd100);
        wr(2'd2, 32'd60);
        wr(2'd3, 32'd10);
        wr(2'd0, 32'd1);
        wait_duty(d);
        pop_chk(d);
        pop_chk({31'd0, sens_out});
        for (int i = 0; i < 2; i++) begin
            wait_duty(d);
            pop_chk(d);
        end
        wait_pwm_high(ok);
        pop_chk({31'd0, ok});
        wr(2'd0, 32'd0);
        pop_chk({31'd0, pwm_out});
        pop_chk({16'd0, duty_now});
        rd(2'd3, d);
        pop_chk(d);

        // async reset while pwm high
        push("rst_pre_duty", 32'd10);
        push("rst_pre_pwm", 32'd1);
        push("rst_async_pwm", 32'd0);
        push("rst_async_duty", 32'd0);
        wr(2'd0, 32'd1);
        wait_duty(d);
        pop_chk(d);
        wait_pwm_high(ok);
        pop_chk({31'd0, ok});
        #2 reset_n = 1'b0;
        #1;
        pop_chk({31'd0, pwm_out});
        pop_chk({16'd0, duty_now});
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) push($sformatf("post_rst_reg%0d", a), 32'd0);
        push("post_rst_idle_duty", 32'd0);
        push("post_rst_idle_pwm", 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            pop_chk(d);
        end
        repeat (250) @(negedge clk);
        pop_chk({16'd0, duty_now});
        pop_chk({31'd0, pwm_out});

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
